pc_gen: RTL and testbench

- Program-counter stage, directly upstream of the fetch stage; drives `pc`, which fetch turns into a ROM word address.
- Holds the architectural PC and advances it by 4 each cycle.
- Applies redirects from branch/jump, trap entry and mret.
- Flags misaligned redirect targets and out-of-ROM fetch addresses, and gates fetch validity through a small state machine.

---
 rtl/pc_gen_pkg.sv | 25 ++
 rtl/pc_gen_if.sv | 47 ++++
 rtl/pc_gen.sv | 98 +++++++++
 tb/tb_pc_gen.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_gen_pkg.sv
// Shared types and helpers for the program-counter stage.
// Imported by the pc_gen interface and top.
package pc_gen_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } pc_state_t;

    localparam int PC_STEP = 4;

    // Upper address bits above the ROM byte range must all be zero.
    function automatic logic in_rom(
        input logic [63:0] addr,
        input int          aw
    );
        return (addr >> (aw + 2)) == 64'd0;
    endfunction

    function automatic logic aligned(input logic [1:0] lsb);
        return lsb == 2'b00;
    endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Redirect-request and fetch-address bundle between
// the control logic (master) and the PC stage (slave).
interface pc_gen_if #(
    parameter int WIDTH = 32
);

    logic             stall;
    logic             branch_taken;
    logic [WIDTH-1:0] branch_target;
    logic             trap_req;
    logic [WIDTH-1:0] trap_addr;
    logic             mret;
    logic [WIDTH-1:0] mepc;
    logic [WIDTH-1:0] pc;
    logic             inst_valid;
    logic             misaligned;
    logic             fetch_fault;

    modport master (
        output stall,
        output branch_taken,
        output branch_target,
        output trap_req,
        output trap_addr,
        output mret,
        output mepc,
        input  pc,
        input  inst_valid,
        input  misaligned,
        input  fetch_fault
    );

    modport slave (
        input  stall,
        input  branch_taken,
        input  branch_target,
        input  trap_req,
        input  trap_addr,
        input  mret,
        input  mepc,
        output pc,
        output inst_valid,
        output misaligned,
        output fetch_fault
    );

endinterface

// File: rtl/pc_gen.sv
// Program-counter stage: holds the architectural PC, applies
// trap/mret/branch redirects and gates fetch validity.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int               WIDTH          = 32,
    parameter int               ROM_ADDR_WIDTH = 10,
    parameter logic [WIDTH-1:0] RESET_ADDR     = '0
) (
    input  logic    clk,
    input  logic    rst,
    pc_gen_if.slave bus
);

    pc_state_t        state_q;
    pc_state_t        state_d;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;
    logic             valid_q;
    logic             mis_q;
    logic             mis_d;
    logic             fault_q;

    logic             redirect;
    logic             advance;
    logic [WIDTH-1:0] tgt;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        mis_d    = 1'b0;
        redirect = 1'b0;
        advance  = 1'b0;
        tgt      = pc_q;

        unique case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (bus.trap_req) begin
                    redirect = 1'b1;
                    tgt      = bus.trap_addr;
                end else if (bus.mret) begin
                    redirect = 1'b1;
                    tgt      = bus.mepc;
                end else if (!bus.stall) begin
                    if (bus.branch_taken) begin
                        redirect = 1'b1;
                        tgt      = bus.branch_target;
                    end else begin
                        advance = 1'b1;
                        tgt     = pc_q + WIDTH'(PC_STEP);
                    end
                end
            end
            FAULT: begin
                if (bus.trap_req) begin
                    redirect = 1'b1;
                    tgt      = bus.trap_addr;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase

        // A misaligned redirect is dropped; the state is left as is.
        if (redirect && !aligned(tgt[1:0])) begin
            mis_d = 1'b1;
        end else if (redirect || advance) begin
            pc_d    = tgt;
            state_d = in_rom(64'(tgt), ROM_ADDR_WIDTH) ? RUN : FAULT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_ADDR;
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= (state_d == RUN);
            mis_q   <= mis_d;
            fault_q <= (state_d == FAULT);
        end
    end

    assign bus.pc          = pc_q;
    assign bus.inst_valid  = valid_q;
    assign bus.misaligned  = mis_q;
    assign bus.fetch_fault = fault_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed and randomized checks of pc_gen against a
// behavioural program-counter model.
module tb_pc_gen;

    localparam int          W        = 32;
    localparam int          AW       = 10;
    localparam logic [31:0] RST_A    = 32'h0;
    localparam logic [31:0] ROM_SIZE = 32'h1000;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [31:0] m_pc;
    bit          m_boot;
    bit          m_fault;
    bit          m_mis;

    pc_gen_if #(.WIDTH(W)) bus ();

    pc_gen #(
        .WIDTH         (W),
        .ROM_ADDR_WIDTH(AW),
        .RESET_ADDR    (RST_A)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: what the PC becomes after one edge given the inputs.
    task automatic model_step();
        logic [31:0] nxt;
        bit          redir;
        if (rst) begin
            m_pc    = RST_A;
            m_boot  = 1;
            m_fault = 0;
            m_mis   = 0;
            return;
        end
        m_mis = 0;
        if (m_boot) begin
            m_boot = 0;
            return;
        end
        redir = 1;
        if (bus.trap_req) nxt = bus.trap_addr;
        else if (m_fault) return;
        else if (bus.mret) nxt = bus.mepc;
        else if (bus.stall) return;
        else if (bus.branch_taken) nxt = bus.branch_target;
        else begin
            nxt   = m_pc + 32'd4;
            redir = 0;
        end
        if (redir && (nxt % 4) != 0) begin
            m_mis = 1;
            return;
        end
        m_pc    = nxt;
        m_fault = (nxt >= ROM_SIZE);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_in(
        input logic        s,
        input logic        b,
        input logic [31:0] bt,
        input logic        t,
        input logic [31:0] ta,
        input logic        m,
        input logic [31:0] me
    );
        bus.stall         = s;
        bus.branch_taken  = b;
        bus.branch_target = bt;
        bus.trap_req      = t;
        bus.trap_addr     = ta;
        bus.mret          = m;
        bus.mepc          = me;
    endtask

    task automatic test_reset();
        logic [31:0] exp_pc [5];
        logic        exp_v  [5];
        exp_pc = '{32'h0, 32'h0, 32'h4, 32'h8, 32'hC};
        exp_v  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0);
        cycle();
        rst = 1'b0;
        checks++;
        if (bus.misaligned !== 1'b0 || bus.fetch_fault !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags mis=%b ff=%b exp 0 0",
                     bus.misaligned, bus.fetch_fault);
        end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) cycle();
            checks++;
            if (bus.pc !== exp_pc[i] || bus.inst_valid !== exp_v[i]) begin
                errors++;
                $display("FAIL free_run[%0d] pc=%h v=%b exp pc=%h v=%b",
                         i, bus.pc, bus.inst_valid, exp_pc[i], exp_v[i]);
            end
        end
    endtask

    task automatic test_branch_stall();
        logic [31:0] exp_pc [4];
        exp_pc = '{32'h100, 32'h100, 32'h100, 32'h104};
        cycle();
        checks++;
        if (bus.pc !== 32'h10) begin
            errors++;
            $display("FAIL pre_branch pc=%h exp 10", bus.pc);
        end
        for (int i = 0; i < 4; i++) begin
            if (i == 0) set_in(0, 1, 32'h100, 0, 0, 0, 0);
            else if (i < 3) set_in(1, 1, 32'h300, 0, 0, 0, 0);
            else set_in(0, 0, 0, 0, 0, 0, 0);
            cycle();
            checks++;
            if (bus.pc !== exp_pc[i] || bus.inst_valid !== 1'b1) begin
                errors++;
                $display("FAIL branch_stall[%0d] pc=%h v=%b exp %h 1",
                         i, bus.pc, bus.inst_valid, exp_pc[i]);
            end
        end
    endtask

    task automatic test_priority();
        set_in(1, 1, 32'h80, 1, 32'h200, 1, 32'h40);
        cycle();
        checks++;
        if (bus.pc !== 32'h200) begin
            errors++;
            $display("FAIL trap_priority pc=%h exp 200", bus.pc);
        end
        set_in(0, 0, 0, 0, 0, 1, 32'h40);
        cycle();
        checks++;
        if (bus.pc !== 32'h40) begin
            errors++;
            $display("FAIL mret pc=%h exp 40", bus.pc);
        end
    endtask

    task automatic test_misaligned();
        set_in(0, 1, 32'h102, 0, 0, 0, 0);
        cycle();
        checks++;
        if (bus.pc !== 32'h40 || bus.misaligned !== 1'b1 ||
            bus.inst_valid !== 1'b1) begin
            errors++;
            $display("FAIL misaligned pc=%h mis=%b v=%b exp 40 1 1",
                     bus.pc, bus.misaligned, bus.inst_valid);
        end
        set_in(0, 0, 0, 0, 0, 0, 0);
        cycle();
        checks++;
        if (bus.pc !== 32'h44 || bus.misaligned !== 1'b0) begin
            errors++;
            $display("FAIL mis_clear pc=%h mis=%b exp 44 0",
                     bus.pc, bus.misaligned);
        end
    endtask

    task automatic test_fault();
        set_in(0, 1, 32'hFFC, 0, 0, 0, 0);
        cycle();
        set_in(0, 0, 0, 0, 0, 0, 0);
        cycle();
        checks++;
        if (bus.pc !== 32'h1000 || bus.fetch_fault !== 1'b1 ||
            bus.inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL rom_wrap pc=%h ff=%b v=%b exp 1000 1 0",
                     bus.pc, bus.fetch_fault, bus.inst_valid);
        end
        set_in(0, 1, 32'h20, 0, 0, 1, 32'h40);
        cycle();
        cycle();
        checks++;
        if (bus.pc !== 32'h1000 || bus.fetch_fault !== 1'b1) begin
            errors++;
            $display("FAIL fault_frozen pc=%h ff=%b exp 1000 1",
                     bus.pc, bus.fetch_fault);
        end
        set_in(0, 0, 0, 1, 32'h300, 0, 0);
        cycle();
        checks++;
        if (bus.pc !== 32'h300 || bus.fetch_fault !== 1'b0 ||
            bus.inst_valid !== 1'b1) begin
            errors++;
            $display("FAIL fault_exit pc=%h ff=%b v=%b exp 300 0 1",
                     bus.pc, bus.fetch_fault, bus.inst_valid);
        end
        set_in(0, 1, 32'h2000, 0, 0, 0, 0);
        cycle();
        checks++;
        if (bus.pc !== 32'h2000 || bus.fetch_fault !== 1'b1) begin
            errors++;
            $display("FAIL branch_oob pc=%h ff=%b exp 2000 1",
                     bus.pc, bus.fetch_fault);
        end
        set_in(0, 0, 0, 1, 32'h301, 0, 0);
        cycle();
        checks++;
        if (bus.pc !== 32'h2000 || bus.misaligned !== 1'b1 ||
            bus.fetch_fault !== 1'b1) begin
            errors++;
            $display("FAIL trap_mis pc=%h mis=%b ff=%b exp 2000 1 1",
                     bus.pc, bus.misaligned, bus.fetch_fault);
        end
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        set_in(0, 1, 32'h500, 0, 0, 0, 0);
        cycle();
        rst = 1'b0;
        checks++;
        if (bus.pc !== RST_A || bus.inst_valid !== 1'b0 ||
            bus.misaligned !== 1'b0 || bus.fetch_fault !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid pc=%h v=%b mis=%b ff=%b exp 0 0 0 0",
                     bus.pc, bus.inst_valid, bus.misaligned,
                     bus.fetch_fault);
        end
        cycle();
        checks++;
        if (bus.pc !== RST_A || bus.inst_valid !== 1'b1) begin
            errors++;
            $display("FAIL boot_exit pc=%h v=%b exp 0 1",
                     bus.pc, bus.inst_valid);
        end
    endtask

    function automatic logic [31:0] rand_tgt();
        logic [31:0] a;
        a = {20'h0, $urandom_range(0, 1023) % 1024 == 0 ? 10'h3FF
             : 10'($urandom_range(0, 1023)), 2'b00};
        if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
        if ($urandom_range(0, 9) == 0) a = a | 32'h0001_0000;
        if ($urandom_range(0, 9) == 0) a = 32'hFFC;
        return a;
    endfunction

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            set_in($urandom_range(0, 3) == 0,
                   $urandom_range(0, 4) == 0, rand_tgt(),
                   $urandom_range(0, 11) == 0, rand_tgt(),
                   $urandom_range(0, 9) == 0, rand_tgt());
            cycle();
            checks++;
            if (bus.pc !== m_pc ||
                bus.inst_valid !== (!m_boot && !m_fault) ||
                bus.misaligned !== m_mis ||
                bus.fetch_fault !== m_fault) begin
                errors++;
                $display("FAIL random[%0d] pc=%h v=%b mis=%b ff=%b exp %h %b %b %b",
                         i, bus.pc, bus.inst_valid, bus.misaligned,
                         bus.fetch_fault, m_pc, !m_boot && !m_fault,
                         m_mis, m_fault);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        m_pc    = RST_A;
        m_boot  = 1;
        m_fault = 0;
        m_mis   = 0;
        rst     = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_branch_stall();
        test_priority();
        test_misaligned();
        test_fault();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
